// File: rtl/trade_pkg.sv
// Shared constants for trade_feeder: action codes, FSM state encoding and frame field offsets.
package trade_pkg;

  typedef logic [4:0] price_t;

  localparam int unsigned PRICE_W = 5;

  localparam logic [15:0] SELL_ALL   = 16'd1;
  localparam logic [15:0] STAY_OUT   = 16'd2;
  localparam logic [15:0] BUY_MORE   = 16'd3;
  localparam logic [15:0] BUY_LOT    = 16'd4;
  localparam logic [15:0] BUY_LITTLE = 16'd7;
  localparam logic [15:0] HOLD       = 16'd8;

  localparam logic [1:0] StFill  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  localparam int unsigned OWN_BIT    = 15;
  localparam int unsigned OLDEST_LSB = 10;
  localparam int unsigned MIDDLE_LSB = 5;
  localparam int unsigned NEWEST_LSB = 0;

  // Actions that change the position and therefore count as trades.
  function automatic logic is_trade(input logic [15:0] action);
    return (action == SELL_ALL) || (action == BUY_MORE) ||
           (action == BUY_LOT) || (action == BUY_LITTLE);
  endfunction

endpackage

// File: rtl/trade_position.sv
// Combinational position update: current shares plus an action code give the next shares
// and an illegal-code flag. Buys saturate at MAX_SHARES.
module trade_position
  import trade_pkg::*;
#(
  parameter int unsigned MAX_SHARES = 15
) (
  input  logic [3:0]  shares,
  input  logic [15:0] action,
  output logic [3:0]  shares_next,
  output logic        illegal
);

  localparam logic [4:0] MaxSat = 5'(MAX_SHARES);

  logic [4:0] add;
  logic [4:0] sum;

  always_comb begin
    add         = 5'd0;
    illegal     = 1'b0;
    shares_next = shares;
    case (action)
      SELL_ALL:       shares_next = 4'd0;
      STAY_OUT, HOLD: shares_next = shares;
      BUY_LITTLE:     add = 5'd1;
      BUY_MORE:       add = 5'd2;
      BUY_LOT:        add = 5'd4;
      default:        illegal = 1'b1;
    endcase
    sum = {1'b0, shares} + add;
    if (add != 5'd0) begin
      shares_next = (sum > MaxSat) ? MaxSat[3:0] : sum[3:0];
    end
  end

endmodule

// File: rtl/trade_feeder.sv
// Price-window feeder: collects a 3-price sliding window, issues a frame, then waits for an action.
// Optional statistics counter enabled by TRADE_FEEDER_STATS_EN.
module trade_feeder
  import trade_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned MAX_SHARES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  price_in,
  input  logic        price_valid,
  output logic        price_ready,
  output logic [15:0] stock_out,
  output logic        stock_valid,
  input  logic [15:0] action_in,
  input  logic        action_valid,
  output logic [3:0]  shares,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic [7:0]  trade_count
);

  localparam int unsigned WaitW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       fill_q, fill_d;
  logic [WaitW-1:0] wait_q, wait_d;
  price_t           oldest_q, middle_q, newest_q;
  logic [15:0]      stock_q, stock_d;
  logic [3:0]       shares_q;
  logic             err_ill_q, err_to_q;

  logic       accept, act, timeout;
  logic [3:0] pos_next;
  logic       pos_illegal;

  assign accept  = (state_q == StFill) && price_valid;
  assign act     = (state_q == StWait) && action_valid;
  assign timeout = (state_q == StWait) && !action_valid && (wait_q == WaitLast);

  trade_position #(
    .MAX_SHARES (MAX_SHARES)
  ) u_position (
    .shares      (shares_q),
    .action      (action_in),
    .shares_next (pos_next),
    .illegal     (pos_illegal)
  );

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    wait_d  = wait_q;
    unique case (state_q)
      StFill: begin
        if (price_valid) begin
          fill_d = fill_q + 2'd1;
          if (fill_q == 2'd2) state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
        wait_d  = '0;
      end
      StWait: begin
        // Window keeps two prices, so one more accept yields the next frame.
        if (act || timeout) begin
          state_d = StFill;
          fill_d  = 2'd2;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    stock_d = stock_q;
    if (accept && (fill_q == 2'd2)) begin
      stock_d[OWN_BIT]                = (shares_q != 4'd0);
      stock_d[OLDEST_LSB +: PRICE_W]  = middle_q;
      stock_d[MIDDLE_LSB +: PRICE_W]  = newest_q;
      stock_d[NEWEST_LSB +: PRICE_W]  = price_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFill;
      fill_q    <= 2'd0;
      wait_q    <= '0;
      oldest_q  <= '0;
      middle_q  <= '0;
      newest_q  <= '0;
      stock_q   <= '0;
      shares_q  <= '0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      wait_q  <= wait_d;
      stock_q <= stock_d;
      if (accept) begin
        oldest_q <= middle_q;
        middle_q <= newest_q;
        newest_q <= price_in;
      end
      if (act) begin
        shares_q  <= pos_next;
        err_ill_q <= err_ill_q | pos_illegal;
      end
      if (timeout) err_to_q <= 1'b1;
    end
  end

`ifdef TRADE_FEEDER_STATS_EN
  logic [7:0] trade_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trade_q <= 8'd0;
    end else if (act && is_trade(action_in) && (trade_q != 8'hFF)) begin
      trade_q <= trade_q + 8'd1;
    end
  end

  assign trade_count = trade_q;
`else
  assign trade_count = 8'd0;
`endif

  assign price_ready = (state_q == StFill);
  assign stock_valid = (state_q == StIssue);
  assign stock_out   = stock_q;
  assign shares      = shares_q;
  assign err_illegal = err_ill_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_trade_feeder.sv
// Self-checking bench for trade_feeder: directed scenarios then random traffic, compared
// every cycle against a price-history / position model.
module tb_trade_feeder;

  localparam int unsigned TIMEOUT    = 15;
  localparam int unsigned MAX_SHARES = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  price_in = '0;
  logic        price_valid = 1'b0;
  logic        price_ready;
  logic [15:0] stock_out;
  logic        stock_valid;
  logic [15:0] action_in = '0;
  logic        action_valid = 1'b0;
  logic [3:0]  shares;
  logic        err_illegal;
  logic        err_timeout;
  logic [7:0]  trade_count;

  always #5 clk = ~clk;

  trade_feeder #(
    .TIMEOUT    (TIMEOUT),
    .MAX_SHARES (MAX_SHARES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .price_in     (price_in),
    .price_valid  (price_valid),
    .price_ready  (price_ready),
    .stock_out    (stock_out),
    .stock_valid  (stock_valid),
    .action_in    (action_in),
    .action_valid (action_valid),
    .shares       (shares),
    .err_illegal  (err_illegal),
    .err_timeout  (err_timeout),
    .trade_count  (trade_count)
  );

  int checks   = 0;
  int failures = 0;

  // Model: prices still needed for a frame, whether a frame is out / an action is awaited.
  int          m_need;
  bit          m_issue;
  bit          m_waiting;
  int          m_wait;
  logic [4:0]  hist[$];
  logic [15:0] m_frame;
  int          m_shares;
  int          m_trades;
  bit          m_eill;
  bit          m_eto;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_need = 3; m_issue = 0; m_waiting = 0; m_wait = 0;
    hist = {5'd0, 5'd0, 5'd0};
    m_frame = '0; m_shares = 0; m_trades = 0; m_eill = 0; m_eto = 0;
  endtask

  function automatic int buy(input int cur, input int n);
    return (cur + n > int'(MAX_SHARES)) ? int'(MAX_SHARES) : cur + n;
  endfunction

  task automatic model_action(input logic [15:0] a);
    case (a)
      16'd1:        begin m_shares = 0; m_trades++; end
      16'd2, 16'd8: ;
      16'd7:        begin m_shares = buy(m_shares, 1); m_trades++; end
      16'd3:        begin m_shares = buy(m_shares, 2); m_trades++; end
      16'd4:        begin m_shares = buy(m_shares, 4); m_trades++; end
      default:      m_eill = 1;
    endcase
  endtask

  function automatic logic [7:0] exp_trades();
`ifdef TRADE_FEEDER_STATS_EN
    return (m_trades > 255) ? 8'hFF : 8'(m_trades);
`else
    return 8'd0;
`endif
  endfunction

  task automatic check_all(input string where);
    chk({where, ":price_ready"}, 16'(price_ready), 16'(!(m_waiting || m_issue)));
    chk({where, ":stock_valid"}, 16'(stock_valid), 16'(m_issue));
    chk({where, ":stock_out"},   stock_out, m_frame);
    chk({where, ":shares"},      16'(shares), 16'(m_shares));
    chk({where, ":err_illegal"}, 16'(err_illegal), 16'(m_eill));
    chk({where, ":err_timeout"}, 16'(err_timeout), 16'(m_eto));
    chk({where, ":trade_count"}, 16'(trade_count), 16'(exp_trades()));
  endtask

  task automatic step(input bit pv, input logic [4:0] p, input bit av, input logic [15:0] a,
                      input string tag);
    price_valid = pv; price_in = p; action_valid = av; action_in = a;
    if (m_issue) begin
      m_issue = 0; m_waiting = 1; m_wait = 0;
    end else if (m_waiting) begin
      if (av) begin
        model_action(a); m_waiting = 0; m_need = 1;
      end else begin
        m_wait++;
        if (m_wait == int'(TIMEOUT)) begin
          m_eto = 1; m_waiting = 0; m_need = 1;
        end
      end
    end else if (pv) begin
      hist.push_back(p);
      void'(hist.pop_front());
      m_need--;
      if (m_need == 0) begin
        m_issue = 1;
        m_frame = {(m_shares != 0), hist[0], hist[1], hist[2]};
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 5'd0, 1'b0, 16'd0, tag);
  endtask

  // New price -> frame cycle -> first WAIT cycle.
  task automatic next_frame(input string tag);
    step(1'b1, 5'($urandom_range(0, 31)), 1'b0, 16'd0, tag);
    idle(tag);
  endtask

  logic [15:0] acts[11] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd7, 16'd8,
                            16'd0, 16'd5, 16'd6, 16'd9, 16'hFFFF};

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;

    // Fill from reset with 10, 10, 10.
    step(1'b1, 5'd10, 1'b0, 16'd0, "fill1");
    step(1'b1, 5'd10, 1'b0, 16'd0, "fill2");
    step(1'b1, 5'd10, 1'b0, 16'd0, "fill3");
    chk("frame_10s", stock_out, 16'b0_01010_01010_01010);
    idle("issue_end");
    chk("pulse_one_cycle", 16'(stock_valid), 16'd0);

    // Buy one, then a single price gives the next sliding frame with own set.
    step(1'b0, 5'd0, 1'b1, 16'd7, "buy1");
    step(1'b1, 5'd12, 1'b0, 16'd0, "slide12");
    chk("frame_own", stock_out, 16'b1_01010_01010_01100);
    idle("wait_after_own");

    // Buy lot four times to saturate, then sell all.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 1'b1, 16'd4, "buy_lot");
      next_frame("buy_lot_frame");
    end
    chk("saturated", 16'(shares), 16'd15);
    step(1'b0, 5'd0, 1'b1, 16'd1, "sell_all");
    chk("sold", 16'(shares), 16'd0);
    next_frame("after_sell");
    chk("own_cleared", 16'(stock_out[15]), 16'd0);

    // Action on the last WAIT cycle is processed, no timeout.
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) idle("late_wait");
    step(1'b0, 5'd0, 1'b1, 16'd3, "late_action");
    chk("late_no_timeout", 16'(err_timeout), 16'd0);
    chk("late_shares", 16'(shares), 16'd2);
    next_frame("late_frame");

    // Full timeout.
    for (int i = 0; i < int'(TIMEOUT); i++) idle("timeout_wait");
    chk("timeout_flag", 16'(err_timeout), 16'd1);
    chk("timeout_ready", 16'(price_ready), 16'd1);
    chk("timeout_shares", 16'(shares), 16'd2);

    // action_valid in FILL is ignored; then an illegal code in WAIT.
    step(1'b0, 5'd0, 1'b1, 16'd7, "fill_action");
    chk("fill_action_ignored", 16'(shares), 16'd2);
    next_frame("illegal_frame");
    step(1'b0, 5'd0, 1'b1, 16'd5, "illegal");
    chk("illegal_flag", 16'(err_illegal), 16'd1);
    chk("illegal_shares", 16'(shares), 16'd2);

    // Reset mid-WAIT, asserted and released away from clock edges.
    next_frame("pre_reset");
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("mid_reset");
    chk("mid_reset_stock", stock_out, 16'd0);
    #3 rst = 1'b1;
    #1;
    step(1'b1, 5'd3, 1'b0, 16'd0, "refill1");
    step(1'b1, 5'd4, 1'b0, 16'd0, "refill2");
    step(1'b1, 5'd5, 1'b0, 16'd0, "refill3");
    idle("refill_wait");
    step(1'b0, 5'd0, 1'b1, 16'd7, "stats7");
    next_frame("stats_f1");
    step(1'b0, 5'd0, 1'b1, 16'd8, "stats8");
    next_frame("stats_f2");
    step(1'b0, 5'd0, 1'b1, 16'd1, "stats1");
`ifdef TRADE_FEEDER_STATS_EN
    chk("trade_count_2", 16'(trade_count), 16'd2);
`else
    chk("trade_count_0", 16'(trade_count), 16'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 7) == 0), acts[$urandom_range(0, 10)], "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trade_feeder.md
TRADE_FEEDER -- requirements
Module: trade_feeder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: cycles to wait in WAIT for an action before giving up.
REQ-002 SHALL have parameter MAX_SHARES, default 15: saturation ceiling of the share counter (at most 15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port price_in, input, 5 bits: unsigned price sample.
REQ-006 SHALL have port price_valid, input, 1 bit: price_in is valid.
REQ-007 SHALL have port price_ready, output, 1 bit: block accepts a price this cycle.
REQ-008 SHALL have port stock_out, output, 16 bits: frame {own, oldest, middle, newest}; bit 15 is own, bits 14:10 oldest, bits 9:5 middle, bits 4:0 newest.
REQ-009 SHALL have port stock_valid, output, 1 bit: one-cycle pulse marking a new frame.
REQ-010 SHALL have port action_in, input, 16 bits: action code from the trading decider.
REQ-011 SHALL have port action_valid, input, 1 bit: action_in is valid.
REQ-012 SHALL have port shares, output, 4 bits: current position.
REQ-013 SHALL have port err_illegal, output, 1 bit: sticky flag for an unknown action code.
REQ-014 SHALL have port err_timeout, output, 1 bit: sticky flag for an action timeout.
REQ-015 SHALL have port trade_count, output, 8 bits: statistics counter.

Function
REQ-016 SHALL implement FSM states FILL, ISSUE and WAIT.
REQ-017 In FILL, price_ready SHALL be 1; a price is accepted when price_valid && price_ready.
REQ-018 On each accept, the window SHALL shift: oldest<=middle, middle<=newest, newest<=price_in.
REQ-019 A fill counter SHALL count accepts 0..3; FILL SHALL go to ISSUE on the accept that makes the count 3.
REQ-020 ISSUE SHALL last exactly one cycle with stock_valid=1, then go to WAIT.
REQ-021 Frame latency SHALL be: stock_valid high in the cycle after the third accepted price.
REQ-022 stock_out SHALL be registered and held stable from ISSUE until the next ISSUE; own = (shares != 0), sampled at ISSUE entry.
REQ-023 In WAIT, price_ready SHALL be 0; action_valid SHALL be ignored in every state except WAIT.
REQ-024 On action_valid in WAIT, shares SHALL update by action_in as follows.
REQ-025 Action 1 (sell all) SHALL set shares to 0.
REQ-026 Action 2 (stay out) and action 8 (hold) SHALL leave shares unchanged.
REQ-027 Action 7 SHALL add 1 to shares, action 3 SHALL add 2, and action 4 SHALL add 4.
REQ-028 Additions SHALL saturate at MAX_SHARES.
REQ-029 Any other action value SHALL leave shares unchanged and set err_illegal.
REQ-030 After an action, the FSM SHALL return to FILL with the fill count at 2, so one new price yields the next sliding frame.
REQ-031 A wait counter SHALL count WAIT cycles; at TIMEOUT cycles without action_valid the block SHALL set err_timeout, treat the action as hold, and return to FILL with count 2.
REQ-032 action_valid arriving in the same cycle the wait counter reaches TIMEOUT SHALL be processed as an action; no timeout SHALL be flagged.
REQ-033 The error flags SHALL clear only on reset.

Reset
REQ-034 Reset SHALL force state FILL and clear the fill and wait counters, stock_out, stock_valid, shares, both error flags and trade_count.
REQ-035 Reset asserted mid-WAIT SHALL abandon the pending frame; no stock_valid SHALL occur until three new prices are accepted.

Configuration
REQ-036 Macro TRADE_FEEDER_STATS_EN SHALL control trade_count.
REQ-037 With TRADE_FEEDER_STATS_EN defined, trade_count SHALL increment on every processed action 1, 3, 4 or 7, and SHALL saturate at 255.
REQ-038 Without TRADE_FEEDER_STATS_EN, trade_count SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-039 Package trade_pkg SHALL hold the action code constants (SELL_ALL=1, STAY_OUT=2, BUY_MORE=3, BUY_LOT=4, BUY_LITTLE=7, HOLD=8), the FSM state encoding, and the frame field offsets.
REQ-040 Sub-module trade_position SHALL be combinational, mapping current shares plus action code to next shares and an illegal flag.

Verification
REQ-041 Fill and issue: accept prices 10, 10, 10 from reset -> stock_out=16'b0_01010_01010_01010 and stock_valid pulses for 1 cycle.
REQ-042 Buy and own bit: then action 7 followed by price 12 -> shares=1 and the next frame is 16'b1_01010_01010_01100.
REQ-043 Buy lot and sell: action 4 four times from shares 1 -> shares saturates at 15; then action 1 -> shares=0 and the next frame has own=0.
REQ-044 Timeout: no action_valid for 15 cycles in WAIT -> err_timeout=1, shares unchanged, price_ready=1 on the next cycle.
REQ-045 Illegal action: action 5 -> err_illegal=1, shares unchanged; action_valid pulsed while in FILL -> no effect.
REQ-046 Mid-operation reset and stats: reset during WAIT -> all outputs 0; with TRADE_FEEDER_STATS_EN defined, actions 7, 8, 1 -> trade_count=2.
